mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 148 ++++++++++++++
 tb/tb_mem_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: two-port arbiter in front of a single shared memory.
//
// An instruction-fetch port (read-only) and a data port (read/write) share one
// memory with a one-cycle read latency. Grants are combinational, so a lone
// request is accepted in the cycle it is raised. A registered owner tag routes
// the returning read data to the port that issued the read, one cycle later.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> conflicts alternate between the ports, and the
//                               first conflict after reset goes to the data port
//                  undefined -> the data port always wins a conflict
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_req, i_addr                 instruction read request and address
//   i_gnt, i_rvalid, i_rdata      instruction grant, read-data valid, read data
//   d_req, d_we, d_addr, d_wdata  data request, write flag, address, write data
//   d_gnt, d_rvalid, d_rdata      data grant, read-data valid, read data
//   m_raddr, m_re                 memory read address and read enable
//   m_waddr, m_wdata, m_we        memory write address, data and enable
//   m_rdata                       memory read data, one cycle after m_re
//   conflicts                     saturating count of cycles with both requests

module mem_arb #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic [AW-1:0] m_raddr,
    output logic          m_re,
    output logic [AW-1:0] m_waddr,
    output logic [DW-1:0] m_wdata,
    output logic          m_we,
    input  logic [DW-1:0] m_rdata,

    output logic [15:0]   conflicts
);

    logic conflict;
    logic i_pend;
    logic d_pend;

    assign conflict = i_req && d_req;

`ifdef MEM_ARB_RR_EN
    // Set when the instruction port is owed the next conflict. Only conflict
    // cycles move it, so lone grants never disturb the alternation.
    logic prio_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_i <= 1'b0;
        end else if (conflict) begin
            prio_i <= ~prio_i;
        end
    end

    // Grants are held low during reset so the memory sees no traffic.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (conflict) begin
                i_gnt = prio_i;
                d_gnt = ~prio_i;
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end
`else
    // Fixed priority: the data port wins every conflict and the instruction
    // port waits until the data port goes quiet.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            d_gnt = d_req;
            i_gnt = i_req && !d_req;
        end
    end
`endif

    // Address and data outputs always follow a defined input when idle so
    // nothing downstream ever sees X; only the enables carry meaning.
    always_comb begin
        m_re    = 1'b0;
        m_we    = 1'b0;
        m_raddr = i_addr;
        m_waddr = d_addr;
        m_wdata = d_wdata;
        if (i_gnt) begin
            m_re = 1'b1;
        end else if (d_gnt) begin
            if (d_we) begin
                m_we = 1'b1;
            end else begin
                m_re    = 1'b1;
                m_raddr = d_addr;
            end
        end
    end

    // Owner tag: remembers which port issued this cycle's read so the data
    // returning next cycle is qualified for that port only. Reset drops any
    // read in flight; it is not replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_pend <= 1'b0;
            d_pend <= 1'b0;
        end else begin
            i_pend <= i_gnt;
            d_pend <= d_gnt && !d_we;
        end
    end

    assign i_rvalid = i_pend;
    assign d_rvalid = d_pend;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    // Contention counter, sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflicts <= 16'h0000;
        end else if (conflict && (conflicts != 16'hFFFF)) begin
            conflicts <= conflicts + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: self-checking bench for mem_arb.
//
// A behavioural memory with one-cycle read latency sits on the m_* side.
// Directed tasks cover reset, single reads, write-then-read, conflicts,
// streaming reads, mid-transaction reset and counter saturation; a randomized
// task compares every cycle against a transaction-level model of the arbiter.
// Build with +define+MEM_ARB_RR_EN to exercise the alternating-priority mode.
//
// Inputs change 1 time unit after posedge clk; outputs are sampled on negedge.

module tb_mem_arb;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] m_raddr, m_waddr;
    logic [DW-1:0] m_wdata;
    logic          m_re, m_we;
    logic [DW-1:0] m_rdata;
    logic [15:0]   conflicts;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [0:255];

    mem_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_raddr(m_raddr), .m_re(m_re), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_we(m_we),
        .m_rdata(m_rdata), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        logic [7:0] b;
        b = 8'(a);
        return (a == 4) ? 16'hA5A5 : {~b, b};
    endfunction

    // Shared memory: preloaded contents, writes land at the edge, reads
    // return data one cycle after the enable.
    initial begin
        for (int a = 0; a < 256; a++) mem[a] = init_val(a);
        m_rdata = '0;
        forever begin
            @(posedge clk);
            if (m_we) mem[m_waddr[7:0]] = m_wdata;
            if (m_re) m_rdata <= mem[m_raddr[7:0]];
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 16'h0004; d_addr = 16'h0004;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_re, m_we} !== 6'b0) begin
                n_bad++;
                $display("[TB] FAIL reset_idle: got gnt/rv/re/we %b want 000000",
                         {i_gnt, d_gnt, i_rvalid, d_rvalid, m_re, m_we});
            end
            n_cmp++;
            if (conflicts !== 16'h0000) begin
                n_bad++; $display("[TB] FAIL reset_conflicts: got %h want 0000", conflicts);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt, m_re} !== 3'b011) begin
            n_bad++; $display("[TB] FAIL first_grant: got i/d/re %b want 011", {i_gnt, d_gnt, m_re});
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (conflicts !== 16'h0001) begin
            n_bad++; $display("[TB] FAIL first_conflict_count: got %h want 0001", conflicts);
        end
        n_cmp++;
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 16'hA5A5) begin
            n_bad++;
            $display("[TB] FAIL first_read_return: got drv %b irv %b data %h want 1 0 a5a5",
                     d_rvalid, i_rvalid, d_rdata);
        end
    endtask

    task automatic test_ifetch();
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h0004;
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt, m_re, m_we} !== 4'b1010 || m_raddr !== 16'h0004) begin
            n_bad++;
            $display("[TB] FAIL ifetch_grant: got i/d/re/we %b raddr %h want 1010 0004",
                     {i_gnt, d_gnt, m_re, m_we}, m_raddr);
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 16'hA5A5) begin
            n_bad++;
            $display("[TB] FAIL ifetch_data: got irv %b drv %b data %h want 1 0 a5a5",
                     i_rvalid, d_rvalid, i_rdata);
        end
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, m_we, m_re} !== 3'b110 || m_waddr !== 16'h0010 || m_wdata !== 16'h1234) begin
            n_bad++;
            $display("[TB] FAIL write_grant: got g/we/re %b waddr %h wdata %h want 110 0010 1234",
                     {d_gnt, m_we, m_re}, m_waddr, m_wdata);
        end
        @(posedge clk); #1;
        d_we = 1'b0; d_wdata = 16'h0000;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, m_we, m_re, d_rvalid} !== 4'b1010 || m_raddr !== 16'h0010) begin
            n_bad++;
            $display("[TB] FAIL read_after_write_grant: got g/we/re/rv %b raddr %h want 1010 0010",
                     {d_gnt, m_we, m_re, d_rvalid}, m_raddr);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 16'h1234 || m_we !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL read_after_write_data: got rv %b data %h we %b want 1 1234 0",
                     d_rvalid, d_rdata, m_we);
        end
    endtask

    task automatic test_conflict();
        logic exp_d;
        do_reset();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 16'h0001; d_addr = 16'h0002;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            n_cmp++;
            if (d_gnt !== exp_d || i_gnt !== !exp_d) begin
                n_bad++;
                $display("[TB] FAIL conflict_grant[%0d]: got i %b d %b want i %b d %b",
                         k, i_gnt, d_gnt, !exp_d, exp_d);
            end
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (conflicts !== 16'd4) begin
            n_bad++; $display("[TB] FAIL conflict_count: got %0d want 4", conflicts);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            i_req = (k < 8); i_addr = 16'(k);
            @(negedge clk);
            n_cmp++;
            if (i_gnt !== (k < 8)) begin
                n_bad++; $display("[TB] FAIL stream_gnt[%0d]: got %b want %b", k, i_gnt, k < 8);
            end
            if (k > 0) begin
                n_cmp++;
                if (i_rvalid !== 1'b1 || i_rdata !== init_val(k - 1)) begin
                    n_bad++;
                    $display("[TB] FAIL stream_data[%0d]: got rv %b data %h want 1 %h",
                             k - 1, i_rvalid, i_rdata, init_val(k - 1));
                end
            end
        end
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h0004; d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b1) begin
            n_bad++; $display("[TB] FAIL midrst_grant: got %b want 1", i_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_re, m_we} !== 6'b0 || conflicts !== 16'h0000) begin
            n_bad++;
            $display("[TB] FAIL midrst_idle: got gnt/rv/re/we %b cnt %h want 000000 0000",
                     {i_gnt, d_gnt, i_rvalid, d_rvalid, m_re, m_we}, conflicts);
        end
        @(posedge clk); #1;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b0 || conflicts !== 16'h0000) begin
            n_bad++;
            $display("[TB] FAIL midrst_after: got rv %b cnt %h want 0 0000", i_rvalid, conflicts);
        end
    endtask

    task automatic test_saturate();
        logic [15:0] exp_cnt;
        @(posedge clk); #1;
        force dut.conflicts = 16'hFFFE;
        #1;
        release dut.conflicts;
        for (int k = 0; k < 5; k++) begin
            i_req = (k < 3); d_req = (k < 3); d_we = 1'b0;
            @(negedge clk);
            exp_cnt = (k == 0) ? 16'hFFFE : 16'hFFFF;
            n_cmp++;
            if (conflicts !== exp_cnt) begin
                n_bad++; $display("[TB] FAIL saturate[%0d]: got %h want %h", k, conflicts, exp_cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic          mi_g, md_g, ev_i, ev_d;
        logic [DW-1:0] ed_i, ed_d;
        logic [15:0]   mcnt;
        logic [DW-1:0] rmem [0:255];
`ifdef MEM_ARB_RR_EN
        logic          last_win_i;
        last_win_i = 1'b1;
`endif
        do_reset();
        for (int a = 0; a < 256; a++) rmem[a] = mem[a];
        mi_g = 1'b0; md_g = 1'b0; ev_i = 1'b0; ev_d = 1'b0;
        ed_i = '0; ed_d = '0; mcnt = 16'h0000;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            // A pending request is held until granted, then may be replaced.
            if (!(i_req && !mi_g)) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = 16'($urandom_range(0, 255));
            end
            if (!(d_req && !md_g)) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 16'($urandom_range(0, 255));
                d_wdata = 16'($urandom);
            end
            @(negedge clk);
            mi_g = 1'b0; md_g = 1'b0;
            if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                if (last_win_i) md_g = 1'b1; else mi_g = 1'b1;
`else
                md_g = 1'b1;
`endif
            end else begin
                mi_g = i_req; md_g = d_req;
            end
            n_cmp++;
            if (i_gnt !== mi_g || d_gnt !== md_g) begin
                n_bad++;
                $display("[TB] FAIL rnd_gnt c%0d: got i %b d %b want i %b d %b", c, i_gnt, d_gnt, mi_g, md_g);
            end
            n_cmp++;
            if (m_re !== (mi_g || (md_g && !d_we)) || m_we !== (md_g && d_we)) begin
                n_bad++;
                $display("[TB] FAIL rnd_en c%0d: got re %b we %b want re %b we %b",
                         c, m_re, m_we, mi_g || (md_g && !d_we), md_g && d_we);
            end
            n_cmp++;
            if ((mi_g && m_raddr !== i_addr) || (md_g && !d_we && m_raddr !== d_addr) ||
                (md_g && d_we && (m_waddr !== d_addr || m_wdata !== d_wdata)) ||
                $isunknown({m_raddr, m_waddr, m_wdata})) begin
                n_bad++;
                $display("[TB] FAIL rnd_bus c%0d: got raddr %h waddr %h wdata %h", c, m_raddr, m_waddr, m_wdata);
            end
            n_cmp++;
            if (i_rvalid !== ev_i || d_rvalid !== ev_d) begin
                n_bad++;
                $display("[TB] FAIL rnd_rvalid c%0d: got i %b d %b want i %b d %b", c, i_rvalid, d_rvalid, ev_i, ev_d);
            end
            if (ev_i) begin
                n_cmp++;
                if (i_rdata !== ed_i) begin
                    n_bad++; $display("[TB] FAIL rnd_idata c%0d: got %h want %h", c, i_rdata, ed_i);
                end
            end
            if (ev_d) begin
                n_cmp++;
                if (d_rdata !== ed_d) begin
                    n_bad++; $display("[TB] FAIL rnd_ddata c%0d: got %h want %h", c, d_rdata, ed_d);
                end
            end
            n_cmp++;
            if (conflicts !== mcnt) begin
                n_bad++; $display("[TB] FAIL rnd_count c%0d: got %h want %h", c, conflicts, mcnt);
            end
            if (i_req && d_req) begin
                if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
`ifdef MEM_ARB_RR_EN
                last_win_i = mi_g;
`endif
            end
            ev_i = mi_g;
            ev_d = md_g && !d_we;
            if (ev_i) ed_i = rmem[i_addr[7:0]];
            if (ev_d) ed_d = rmem[d_addr[7:0]];
            if (md_g && d_we) rmem[d_addr[7:0]] = d_wdata;
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_write_read();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
